seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter that drives a 1-bit stimulus line with a programmable W-bit pattern, MSB first. The default pattern is 101101.
It emits a requested number of frames, with an optional idle gap between frames, and flags each frame end and the end of the burst.
It is the source side of the team's serial sequence-detector blocks, used for on-chip self-test and loopback.

Parameters:
W, 6, pattern width in bits (2..16)
DEFAULT_PAT, 6'b101101, pattern register value after reset
CNT_W, 4, width of the frame-repeat count
GAP, 0, idle bits inserted between consecutive frames (0 = back-to-back)
IDLE_BIT, 1'b0, level driven on x when not shifting pattern bits

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
load_pat  in  1  write pat_in into the pattern register (honoured in IDLE only)
pat_in  in  W  new pattern value
start  in  1  begin a burst (honoured in IDLE only)
rep_in  in  CNT_W  number of frames in the burst, sampled on start
abort  in  1  synchronous abort of a burst in progress
x  out  1  serial data, registered
busy  out  1  high while a burst is in progress
frame_done  out  1  one-cycle pulse while the last bit of each frame is on x
done  out  1  one-cycle pulse while the last bit of the final frame is on x

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pattern register=DEFAULT_PAT, counters=0.
  - x=IDLE_BIT, busy=0, frame_done=0, done=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - x=IDLE_BIT, busy=0.
  - load_pat=1: pattern register <= pat_in at this edge.
  - start=1 with rep_in!=0: latch rep_in; state<=SHIFT; x<=pat[W-1] and busy<=1 at the same edge. First pattern bit is visible the cycle after start.
    - If load_pat is also high in that cycle, the burst uses pat_in.
  - start=1 with rep_in==0: ignored; stays IDLE, no pulses.
- SHIFT:
  - Bit index i runs from W-1 down to 0; one bit per clock on x.
  - The cycle x carries bit 0: frame_done=1. Frame counter increments at the next edge.
  - Final frame: done=1 together with frame_done. The next edge returns to IDLE with x=IDLE_BIT, busy=0. No trailing gap.
  - Non-final frame, GAP=0: the next edge drives pat[W-1] again (continuous stream).
  - Non-final frame, GAP>0: enter GAP.
- GAP:
  - x=IDLE_BIT for exactly GAP cycles, then SHIFT restarts at pat[W-1].
  - busy stays 1.
- Busy-time inputs:
  - start while busy: ignored.
  - load_pat while busy: ignored; the pattern register is unchanged.
  - rep_in changes while busy: no effect.
- abort=1 in SHIFT or GAP:
  - Next edge: IDLE, x=IDLE_BIT, busy=0.
  - No frame_done or done for the cut frame.
  - Pattern register is preserved.
  - abort has priority over every other event in the same cycle.
  - abort in IDLE: no effect.
- Reset mid-burst: immediate return to the reset values, including pattern=DEFAULT_PAT.
- Burst length in cycles = rep_in*W + (rep_in-1)*GAP.
- Frame counter wraps never: the maximum is 2^CNT_W-1 frames, compared by equality.

Decomposition:
- Shared package seq_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2;
  - the default pattern constant PAT_101101=6'b101101.
- One natural sub-module: pattern_piso, a W-bit parallel-load, MSB-first shift register with load and shift enables.
- Bit, gap and frame counters plus the FSM stay in seq_pattern_tx.

Test Plan:
- Reset check: hold rst=0 then release, idle 5 cycles -> x=0, busy=0, frame_done=0, done=0. An internal read of the pattern register equals 101101.
- Single frame: start, rep_in=1 (GAP=0):
  - x = 1,0,1,1,0,1 on cycles 1..6 after start;
  - busy=1 on cycles 1..6, 0 on cycle 7;
  - frame_done=done=1 on cycle 6 only.
- Back-to-back and gap: rep_in=2.
  - GAP=0 -> x = 101101101101 over 12 cycles; frame_done on cycles 6 and 12; done on cycle 12 only.
  - GAP=2 -> x = 101101 00 101101; busy for 14 cycles.
- Pattern load with start: load_pat=1, pat_in=110011, start=1, rep_in=1, all in the same cycle -> x = 1,1,0,0,1,1.
  - A later load_pat while busy leaves the pattern at 110011.
- Abort and ignored start:
  - rep_in=3, abort asserted on cycle 4 -> x=0 and busy=0 from cycle 5; no frame_done or done.
  - start pulsed mid-burst -> burst length unchanged.
- Zero count and reset mid-burst:
  - start with rep_in=0 -> busy stays 0.
  - rst=0 during frame 2 -> outputs are at reset values asynchronously, and the pattern reverts to 101101.

Source files
------------

// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and the reset pattern fed to the team's sequence-detector blocks.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [5:0] PAT_101101 = 6'b101101;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control/status bundle of the pattern transmitter; the stimulus source is the
// master and seq_pattern_tx is the slave.
interface seq_pattern_tx_if #(
  parameter int W     = 6,
  parameter int CNT_W = 4
);
  import seq_pkg::*;

  logic             load_pat;
  logic [W-1:0]     pat_in;
  logic             start;
  logic [CNT_W-1:0] rep_in;
  logic             abort;
  logic             x;
  logic             busy;
  logic             frame_done;
  logic             done;

  modport master (
    output load_pat, pat_in, start, rep_in, abort,
    input  x, busy, frame_done, done
  );

  modport slave (
    input  load_pat, pat_in, start, rep_in, abort,
    output x, busy, frame_done, done
  );

endinterface

// File: rtl/seq_pattern_tx_piso.sv
// W-bit parallel-load shift register; MSB is the next pattern bit to send.
module pattern_piso
  import seq_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] shreg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = shreg_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends rep_in frames of the W-bit pattern MSB
// first on x, with an optional idle gap between frames.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int             W           = 6,
  parameter logic [W-1:0]   DEFAULT_PAT = W'(PAT_101101),
  parameter int             CNT_W       = 4,
  parameter int             GAP         = 0,
  parameter logic           IDLE_BIT    = 1'b0
) (
  input logic                clk,
  input logic                rst,
  seq_pattern_tx_if.slave    bus
);

  localparam int IDX_W = $clog2(W);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(W - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_e           state_q;
  logic [W-1:0]     pat_q;
  logic [CNT_W-1:0] rep_q;
  logic [CNT_W-1:0] frameCnt_q;
  logic [IDX_W-1:0] bitIdx_q;
  logic [GAP_W-1:0] gapCnt_q;
  logic             x_q;
  logic             busy_q;
  logic             frameDone_q;
  logic             done_q;

  logic [W-1:0]     pat_d;
  logic             startOk;
  logic             lastFrame;
  logic             pisoLoad;
  logic             pisoShift;
  logic [W-1:0]     pisoData;
  logic             pisoMsb;

  // A load in the start cycle takes effect for the burst being started.
  assign pat_d     = bus.load_pat ? bus.pat_in : pat_q;
  assign startOk   = bus.start && (bus.rep_in != '0);
  assign lastFrame = (frameCnt_q + 1'b1) == rep_q;

  // The shifter is always loaded with the pattern minus its MSB, because the
  // MSB goes straight onto x at the same edge.
  always_comb begin
    pisoLoad  = 1'b0;
    pisoShift = 1'b0;
    pisoData  = {pat_q[W-2:0], 1'b0};
    unique case (state_q)
      ST_IDLE: begin
        if (startOk) begin
          pisoLoad = 1'b1;
          pisoData = {pat_d[W-2:0], 1'b0};
        end
      end
      ST_SHIFT: begin
        if (!bus.abort) begin
          if (bitIdx_q != '0) begin
            pisoShift = 1'b1;
          end else if (!lastFrame && (GAP == 0)) begin
            pisoLoad = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (!bus.abort && (gapCnt_q == '0)) begin
          pisoLoad = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pattern_piso #(.W(W)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (pisoLoad),
    .shift_i (pisoShift),
    .data_i  (pisoData),
    .msb_o   (pisoMsb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pat_q       <= DEFAULT_PAT;
      rep_q       <= '0;
      frameCnt_q  <= '0;
      bitIdx_q    <= '0;
      gapCnt_q    <= '0;
      x_q         <= IDLE_BIT;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.load_pat) begin
            pat_q <= bus.pat_in;
          end
          if (startOk) begin
            rep_q      <= bus.rep_in;
            frameCnt_q <= '0;
            bitIdx_q   <= IDX_MAX;
            x_q        <= pat_d[W-1];
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            x_q     <= IDLE_BIT;
            busy_q  <= 1'b0;
          end else if (bitIdx_q != '0) begin
            x_q         <= pisoMsb;
            bitIdx_q    <= bitIdx_q - 1'b1;
            frameDone_q <= (bitIdx_q == IDX_W'(1));
            done_q      <= (bitIdx_q == IDX_W'(1)) && lastFrame;
          end else begin
            // Bit 0 is on x now: close the frame.
            frameCnt_q <= frameCnt_q + 1'b1;
            if (lastFrame) begin
              state_q <= ST_IDLE;
              x_q     <= IDLE_BIT;
              busy_q  <= 1'b0;
            end else if (GAP == 0) begin
              x_q      <= pat_q[W-1];
              bitIdx_q <= IDX_MAX;
            end else begin
              x_q      <= IDLE_BIT;
              gapCnt_q <= GAP_INIT;
              state_q  <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            x_q     <= IDLE_BIT;
            busy_q  <= 1'b0;
          end else if (gapCnt_q == '0) begin
            x_q      <= pat_q[W-1];
            bitIdx_q <= IDX_MAX;
            state_q  <= ST_SHIFT;
          end else begin
            gapCnt_q <= gapCnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          x_q     <= IDLE_BIT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x          = x_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frameDone_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a back-to-back (GAP=0) and a gapped (GAP=2)
// instance share stimulus and are compared against a per-cycle stream model.
module tb_seq_pattern_tx;

  typedef struct packed {
    logic x;
    logic busy;
    logic fd;
    logic dn;
  } obs_t;

  localparam obs_t IDLE_OBS = 4'b0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       loadPat;
  logic [5:0] patIn;
  logic       start;
  logic [3:0] repIn;
  logic       abort;

  int   vectors     = 0;
  int   miscompares = 0;
  logic [5:0] patModel;
  obs_t expQ0[$];
  obs_t expQ2[$];
  obs_t obs0;
  obs_t obs2;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.W(6), .CNT_W(4)) bus0 ();
  seq_pattern_tx_if #(.W(6), .CNT_W(4)) bus2 ();

  assign bus0.load_pat = loadPat;
  assign bus0.pat_in   = patIn;
  assign bus0.start    = start;
  assign bus0.rep_in   = repIn;
  assign bus0.abort    = abort;
  assign bus2.load_pat = loadPat;
  assign bus2.pat_in   = patIn;
  assign bus2.start    = start;
  assign bus2.rep_in   = repIn;
  assign bus2.abort    = abort;

  assign obs0 = {bus0.x, bus0.busy, bus0.frame_done, bus0.done};
  assign obs2 = {bus2.x, bus2.busy, bus2.frame_done, bus2.done};

  seq_pattern_tx #(.W(6), .CNT_W(4), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  seq_pattern_tx #(.W(6), .CNT_W(4), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // Expected output stream, one entry per cycle after start, from the frame
  // and gap rules; the gap-0 stream is padded with idle to the gapped length.
  function automatic void build_model(input logic [5:0] pat, input int rep);
    expQ0.delete();
    expQ2.delete();
    for (int f = 0; f < rep; f++) begin
      for (int b = 5; b >= 0; b--) begin
        expQ0.push_back({pat[b], 1'b1, (b == 0), ((b == 0) && (f == rep - 1))});
        expQ2.push_back({pat[b], 1'b1, (b == 0), ((b == 0) && (f == rep - 1))});
      end
      if (f < rep - 1) begin
        for (int g = 0; g < 2; g++) expQ2.push_back(4'b0100);
      end
    end
    expQ0.push_back(IDLE_OBS);
    expQ2.push_back(IDLE_OBS);
    while (expQ0.size() < expQ2.size()) expQ0.push_back(IDLE_OBS);
  endfunction

  function automatic void apply_abort(input int a);
    for (int i = a + 1; i < expQ0.size(); i++) expQ0[i] = IDLE_OBS;
    for (int i = a + 1; i < expQ2.size(); i++) expQ2[i] = IDLE_OBS;
  endfunction

  task automatic start_burst(input logic ld, input logic [5:0] p, input logic [3:0] rep);
    loadPat = ld;
    patIn   = p;
    repIn   = rep;
    start   = 1'b1;
    @(negedge clk);
    loadPat = 1'b0;
    start   = 1'b0;
    patIn   = 6'($urandom);
    repIn   = 4'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    vectors += 4;
    if (obs0 !== IDLE_OBS) begin
      miscompares++;
      $display("[TB] FAIL reset outputs gap0: got %b expected %b", obs0, IDLE_OBS);
    end
    if (obs2 !== IDLE_OBS) begin
      miscompares++;
      $display("[TB] FAIL reset outputs gap2: got %b expected %b", obs2, IDLE_OBS);
    end
    if (dut0.pat_q !== 6'b101101) begin
      miscompares++;
      $display("[TB] FAIL reset pattern gap0: got %b expected 101101", dut0.pat_q);
    end
    if (dut2.pat_q !== 6'b101101) begin
      miscompares++;
      $display("[TB] FAIL reset pattern gap2: got %b expected 101101", dut2.pat_q);
    end
    patModel = 6'b101101;
  endtask

  task automatic test_single_frame;
    build_model(patModel, 1);
    start_burst(1'b0, 6'b000000, 4'd1);
    for (int i = 0; i < expQ0.size(); i++) begin
      vectors += 2;
      if (obs0 !== expQ0[i]) begin
        miscompares++;
        $display("[TB] FAIL single gap0 cycle %0d: got %b expected %b", i + 1, obs0, expQ0[i]);
      end
      if (obs2 !== expQ2[i]) begin
        miscompares++;
        $display("[TB] FAIL single gap2 cycle %0d: got %b expected %b", i + 1, obs2, expQ2[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    build_model(patModel, 2);
    start_burst(1'b0, 6'b000000, 4'd2);
    for (int i = 0; i < expQ2.size(); i++) begin
      vectors += 2;
      if (obs0 !== expQ0[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b gap0 cycle %0d: got %b expected %b", i + 1, obs0, expQ0[i]);
      end
      if (obs2 !== expQ2[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b gap2 cycle %0d: got %b expected %b", i + 1, obs2, expQ2[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_with_start;
    patModel = 6'b110011;
    build_model(patModel, 1);
    start_burst(1'b1, 6'b110011, 4'd1);
    for (int i = 0; i < expQ2.size(); i++) begin
      vectors += 2;
      if (obs0 !== expQ0[i]) begin
        miscompares++;
        $display("[TB] FAIL loadstart gap0 cycle %0d: got %b expected %b", i + 1, obs0, expQ0[i]);
      end
      if (obs2 !== expQ2[i]) begin
        miscompares++;
        $display("[TB] FAIL loadstart gap2 cycle %0d: got %b expected %b", i + 1, obs2, expQ2[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_inputs;
    build_model(patModel, 2);
    start_burst(1'b0, 6'b000000, 4'd2);
    for (int i = 0; i < expQ2.size(); i++) begin
      if (i == 2) begin
        loadPat = 1'b1;
        patIn   = 6'b000111;
        start   = 1'b1;
        repIn   = 4'd9;
      end else if (i == 3) begin
        loadPat = 1'b0;
        start   = 1'b0;
      end
      vectors += 2;
      if (obs0 !== expQ0[i]) begin
        miscompares++;
        $display("[TB] FAIL busyin gap0 cycle %0d: got %b expected %b", i + 1, obs0, expQ0[i]);
      end
      if (obs2 !== expQ2[i]) begin
        miscompares++;
        $display("[TB] FAIL busyin gap2 cycle %0d: got %b expected %b", i + 1, obs2, expQ2[i]);
      end
      @(negedge clk);
    end
    vectors += 2;
    if (dut0.pat_q !== patModel) begin
      miscompares++;
      $display("[TB] FAIL busyin pattern gap0: got %b expected %b", dut0.pat_q, patModel);
    end
    if (dut2.pat_q !== patModel) begin
      miscompares++;
      $display("[TB] FAIL busyin pattern gap2: got %b expected %b", dut2.pat_q, patModel);
    end
  endtask

  task automatic test_abort;
    build_model(patModel, 3);
    apply_abort(3);
    start_burst(1'b0, 6'b000000, 4'd3);
    for (int i = 0; i < expQ2.size(); i++) begin
      abort = (i == 3);
      vectors += 2;
      if (obs0 !== expQ0[i]) begin
        miscompares++;
        $display("[TB] FAIL abort gap0 cycle %0d: got %b expected %b", i + 1, obs0, expQ0[i]);
      end
      if (obs2 !== expQ2[i]) begin
        miscompares++;
        $display("[TB] FAIL abort gap2 cycle %0d: got %b expected %b", i + 1, obs2, expQ2[i]);
      end
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  task automatic test_zero_count;
    start_burst(1'b0, 6'b000000, 4'd0);
    for (int i = 0; i < 4; i++) begin
      vectors += 2;
      if (obs0 !== IDLE_OBS) begin
        miscompares++;
        $display("[TB] FAIL zerocount gap0 cycle %0d: got %b expected %b", i + 1, obs0, IDLE_OBS);
      end
      if (obs2 !== IDLE_OBS) begin
        miscompares++;
        $display("[TB] FAIL zerocount gap2 cycle %0d: got %b expected %b", i + 1, obs2, IDLE_OBS);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic       ld;
    logic [5:0] p;
    int         rep;
    int         abortAt;
    for (int n = 0; n < 20; n++) begin
      ld  = 1'($urandom_range(0, 1));
      p   = 6'($urandom);
      rep = int'($urandom_range(1, 4));
      if (ld) patModel = p;
      build_model(patModel, rep);
      abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, expQ2.size() - 1)) : -1;
      if (abortAt >= 0) apply_abort(abortAt);
      start_burst(ld, p, 4'(rep));
      for (int i = 0; i < expQ2.size(); i++) begin
        abort = (i == abortAt);
        vectors += 2;
        if (obs0 !== expQ0[i]) begin
          miscompares++;
          $display("[TB] FAIL random%0d gap0 cycle %0d: got %b expected %b", n, i + 1, obs0, expQ0[i]);
        end
        if (obs2 !== expQ2[i]) begin
          miscompares++;
          $display("[TB] FAIL random%0d gap2 cycle %0d: got %b expected %b", n, i + 1, obs2, expQ2[i]);
        end
        @(negedge clk);
      end
      abort = 1'b0;
    end
  endtask

  task automatic test_reset_mid_burst;
    build_model(patModel, 3);
    start_burst(1'b0, 6'b000000, 4'd3);
    for (int i = 0; i < 8; i++) begin
      vectors += 2;
      if (obs0 !== expQ0[i]) begin
        miscompares++;
        $display("[TB] FAIL midreset gap0 cycle %0d: got %b expected %b", i + 1, obs0, expQ0[i]);
      end
      if (obs2 !== expQ2[i]) begin
        miscompares++;
        $display("[TB] FAIL midreset gap2 cycle %0d: got %b expected %b", i + 1, obs2, expQ2[i]);
      end
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    vectors += 4;
    if (obs0 !== IDLE_OBS) begin
      miscompares++;
      $display("[TB] FAIL midreset async gap0: got %b expected %b", obs0, IDLE_OBS);
    end
    if (obs2 !== IDLE_OBS) begin
      miscompares++;
      $display("[TB] FAIL midreset async gap2: got %b expected %b", obs2, IDLE_OBS);
    end
    if (dut0.pat_q !== 6'b101101) begin
      miscompares++;
      $display("[TB] FAIL midreset pattern gap0: got %b expected 101101", dut0.pat_q);
    end
    if (dut2.pat_q !== 6'b101101) begin
      miscompares++;
      $display("[TB] FAIL midreset pattern gap2: got %b expected 101101", dut2.pat_q);
    end
    @(negedge clk);
    rst      = 1'b1;
    patModel = 6'b101101;
    @(negedge clk);
    build_model(patModel, 1);
    start_burst(1'b0, 6'b000000, 4'd1);
    for (int i = 0; i < expQ0.size(); i++) begin
      vectors += 2;
      if (obs0 !== expQ0[i]) begin
        miscompares++;
        $display("[TB] FAIL postreset gap0 cycle %0d: got %b expected %b", i + 1, obs0, expQ0[i]);
      end
      if (obs2 !== expQ2[i]) begin
        miscompares++;
        $display("[TB] FAIL postreset gap2 cycle %0d: got %b expected %b", i + 1, obs2, expQ2[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst      = 1'b0;
    loadPat  = 1'b0;
    patIn    = '0;
    start    = 1'b0;
    repIn    = '0;
    abort    = 1'b0;
    patModel = 6'b101101;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_load_with_start();
    test_busy_inputs();
    test_abort();
    test_zero_count();
    test_random();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
